// File: rtl/ace_pkg.sv
// Shared ACE snoop-channel types: snoop codes, CR response bit map, cache state update codes
// and the default channel/port structs used by the snoop responder.
package ace_pkg;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t ReadOnce           = 4'b0000;
  localparam acsnoop_t ReadShared         = 4'b0001;
  localparam acsnoop_t ReadClean          = 4'b0010;
  localparam acsnoop_t ReadNotSharedDirty = 4'b0011;
  localparam acsnoop_t ReadUnique         = 4'b0111;
  localparam acsnoop_t CleanShared        = 4'b1000;
  localparam acsnoop_t CleanInvalid       = 4'b1001;
  localparam acsnoop_t MakeInvalid        = 4'b1101;

  // Packed MSB first: was_unique is bit 4, data_transfer is bit 0.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef enum logic [1:0] {
    UPD_NONE         = 2'd0,
    UPD_SHARED_CLEAN = 2'd1,
    UPD_INVALID      = 2'd2,
    UPD_UNIQUE_CLEAN = 2'd3
  } snoop_upd_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    acsnoop_t      snoop;
    logic [2:0]    prot;
  } ac_chan_t;

  typedef struct packed {
    crresp_t resp;
  } cr_chan_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    cr_chan_t cr;
    logic     cr_valid;
    cd_chan_t cd;
    logic     cd_valid;
  } snoop_resp_t;

endpackage

// File: rtl/ace_snoop_responder_if.sv
// Cache-side bundle of the snoop responder: tag lookup, result, line data stream and state update.
interface ace_snoop_responder_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  import ace_pkg::*;

  logic                 lookup_valid_o;
  logic                 lookup_ready_i;
  logic [AddrWidth-1:0] lookup_addr_o;
  logic                 result_valid_i;
  logic                 hit_i;
  logic                 dirty_i;
  logic                 unique_i;
  logic                 line_valid_i;
  logic                 line_ready_o;
  logic [DataWidth-1:0] line_data_i;
  logic                 upd_valid_o;
  logic                 upd_ready_i;
  snoop_upd_e           upd_state_o;

  modport slave (
    output lookup_valid_o, lookup_addr_o, line_ready_o, upd_valid_o, upd_state_o,
    input  lookup_ready_i, result_valid_i, hit_i, dirty_i, unique_i,
           line_valid_i, line_data_i, upd_ready_i
  );

  modport master (
    input  lookup_valid_o, lookup_addr_o, line_ready_o, upd_valid_o, upd_state_o,
    output lookup_ready_i, result_valid_i, hit_i, dirty_i, unique_i,
           line_valid_i, line_data_i, upd_ready_i
  );

endinterface

// File: rtl/ace_snoop_resp_decoder.sv
// Pure combinational map from (snoop type, line state) to the CR response and cache state update.
module ace_snoop_resp_decoder
  import ace_pkg::*;
(
  input  acsnoop_t   snoop_i,
  input  logic       hit_i,
  input  logic       dirty_i,
  input  logic       unique_i,
  output crresp_t    resp_o,
  output logic       upd_req_o,
  output snoop_upd_e upd_state_o
);

  always_comb begin
    resp_o      = '0;
    upd_req_o   = 1'b0;
    upd_state_o = UPD_NONE;
    if (hit_i) begin
      case (snoop_i)
        ReadOnce: begin
          resp_o.data_transfer = 1'b1;
          resp_o.is_shared     = 1'b1;
          resp_o.was_unique    = unique_i;
        end
        ReadShared, ReadClean, ReadNotSharedDirty: begin
          resp_o.data_transfer = 1'b1;
          resp_o.is_shared     = 1'b1;
          resp_o.pass_dirty    = dirty_i;
          resp_o.was_unique    = unique_i;
          upd_req_o            = 1'b1;
          upd_state_o          = UPD_SHARED_CLEAN;
        end
        ReadUnique: begin
          resp_o.data_transfer = 1'b1;
          resp_o.pass_dirty    = dirty_i;
          resp_o.was_unique    = unique_i;
          upd_req_o            = 1'b1;
          upd_state_o          = UPD_INVALID;
        end
        CleanInvalid: begin
          resp_o.data_transfer = dirty_i;
          resp_o.pass_dirty    = dirty_i;
          resp_o.was_unique    = unique_i;
          upd_req_o            = 1'b1;
          upd_state_o          = UPD_INVALID;
        end
        CleanShared: begin
          resp_o.data_transfer = dirty_i;
          resp_o.pass_dirty    = dirty_i;
          resp_o.is_shared     = 1'b1;
          resp_o.was_unique    = unique_i;
          upd_req_o            = dirty_i;
          upd_state_o          = dirty_i ? UPD_SHARED_CLEAN : UPD_NONE;
        end
        MakeInvalid: begin
          upd_req_o   = 1'b1;
          upd_state_o = UPD_INVALID;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks up the local cache, updates its
// state, returns CR and streams the line on CD when data transfer is required.
module ace_snoop_responder #(
  parameter type         ac_chan_t    = ace_pkg::ac_chan_t,
  parameter type         cr_chan_t    = ace_pkg::cr_chan_t,
  parameter type         cd_chan_t    = ace_pkg::cd_chan_t,
  parameter type         snoop_req_t  = ace_pkg::snoop_req_t,
  parameter type         snoop_resp_t = ace_pkg::snoop_resp_t,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned LineBeats    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  snoop_req_t            snoop_req_i,
  output snoop_resp_t           snoop_resp_o,
  ace_snoop_responder_if.slave  cache_if
);
  import ace_pkg::*;

  localparam int unsigned LineBytes = LineBeats * DataWidth / 8;
  localparam int unsigned OffBits   = (LineBytes > 1) ? $clog2(LineBytes) : 1;
  localparam int unsigned BeatW     = (LineBeats > 1) ? $clog2(LineBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LineBeats - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESULT, S_UPDATE, S_CR, S_CD
  } state_e;

  state_e               r_state, w_state_nxt;
  ac_chan_t             r_ac;
  crresp_t              r_resp;
  snoop_upd_e           r_upd_state;
  logic [BeatW-1:0]     r_beat;

  crresp_t              w_dec_resp;
  logic                 w_dec_upd_req;
  snoop_upd_e           w_dec_upd_state;
  logic                 w_ac_hs;
  logic                 w_result_take;
  logic                 w_beat_hs;
  logic                 w_last;
  logic [AddrWidth-1:0] w_line_addr;
  cr_chan_t             w_cr;
  cd_chan_t             w_cd;
  logic                 w_unused;

  assign w_unused = ^r_ac.prot;

  ace_snoop_resp_decoder u_dec (
    .snoop_i     (r_ac.snoop),
    .hit_i       (cache_if.hit_i),
    .dirty_i     (cache_if.dirty_i),
    .unique_i    (cache_if.unique_i),
    .resp_o      (w_dec_resp),
    .upd_req_o   (w_dec_upd_req),
    .upd_state_o (w_dec_upd_state)
  );

  always_comb begin
    w_line_addr              = AddrWidth'(r_ac.addr);
    w_line_addr[OffBits-1:0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_ac        <= '0;
      r_resp      <= '0;
      r_upd_state <= UPD_NONE;
      r_beat      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ac_hs) r_ac <= snoop_req_i.ac;
      if (w_result_take) begin
        r_resp      <= w_dec_resp;
        r_upd_state <= w_dec_upd_state;
      end
      if (w_beat_hs) r_beat <= w_last ? '0 : r_beat + BeatW'(1);
    end
  end

  always_comb begin
    w_state_nxt             = r_state;
    snoop_resp_o            = '0;
    w_cr                    = '0;
    w_cd                    = '0;
    w_ac_hs                 = 1'b0;
    w_result_take           = 1'b0;
    w_beat_hs               = 1'b0;
    w_last                  = (r_beat == LastBeat);
    cache_if.lookup_valid_o = 1'b0;
    cache_if.lookup_addr_o  = w_line_addr;
    cache_if.line_ready_o   = 1'b0;
    cache_if.upd_valid_o    = 1'b0;
    cache_if.upd_state_o    = UPD_NONE;

    case (r_state)
      S_IDLE: begin
        snoop_resp_o.ac_ready = 1'b1;
        if (snoop_req_i.ac_valid) begin
          w_ac_hs     = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_if.lookup_valid_o = 1'b1;
        if (cache_if.lookup_ready_i) w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        // No update needed: go straight to CR so UPDATE costs no cycle.
        if (cache_if.result_valid_i) begin
          w_result_take = 1'b1;
          w_state_nxt   = w_dec_upd_req ? S_UPDATE : S_CR;
        end
      end
      S_UPDATE: begin
        cache_if.upd_valid_o = 1'b1;
        cache_if.upd_state_o = r_upd_state;
        if (cache_if.upd_ready_i) w_state_nxt = S_CR;
      end
      S_CR: begin
        snoop_resp_o.cr_valid = 1'b1;
        w_cr.resp             = r_resp;
        if (snoop_req_i.cr_ready) w_state_nxt = r_resp.data_transfer ? S_CD : S_IDLE;
      end
      S_CD: begin
        snoop_resp_o.cd_valid = cache_if.line_valid_i;
        cache_if.line_ready_o = snoop_req_i.cd_ready;
        w_cd.data             = cache_if.line_data_i;
        w_cd.last             = w_last;
        if (cache_if.line_valid_i && snoop_req_i.cd_ready) begin
          w_beat_hs = 1'b1;
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    snoop_resp_o.cr = w_cr;
    snoop_resp_o.cd = w_cd;
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: walks whole snoop transactions against hand-derived
// CR responses, update codes and CD beat framing, including stalls, back-to-back AC and reset abort.
module tb_ace_snoop_responder;
  import ace_pkg::*;

  logic        clk;
  logic        rst_n;
  snoop_req_t  req;
  snoop_resp_t rsp;

  int unsigned n_checks;
  int unsigned n_fails;

  ace_snoop_responder_if #(.AddrWidth(64), .DataWidth(64)) cif ();

  ace_snoop_responder #(
    .AddrWidth (64),
    .DataWidth (64),
    .LineBeats (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .snoop_req_i  (req),
    .snoop_resp_o (rsp),
    .cache_if     (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cache_inputs();
    cif.lookup_ready_i = 1'b0;
    cif.result_valid_i = 1'b0;
    cif.hit_i          = 1'b0;
    cif.dirty_i        = 1'b0;
    cif.unique_i       = 1'b0;
    cif.line_valid_i   = 1'b0;
    cif.line_data_i    = '0;
    cif.upd_ready_i    = 1'b0;
  endtask

  task automatic run_snoop(input logic [3:0] snp, input logic [63:0] addr,
                           input logic hit, input logic dirty, input logic uniq,
                           input logic [4:0] exp_resp, input logic exp_upd,
                           input logic [1:0] exp_ust, input logic stall,
                           input logic hold_ac, input int abort_beat);
    logic [63:0] d;
    check("ac_ready_idle", 64'(rsp.ac_ready), 64'd1);
    req.ac.addr  = addr;
    req.ac.snoop = snp;
    req.ac.prot  = 3'b010;
    req.ac_valid = 1'b1;
    step();
    if (!hold_ac) req.ac_valid = 1'b0;
    check("lkp_valid", 64'(cif.lookup_valid_o), 64'd1);
    check("lkp_addr", cif.lookup_addr_o, addr & ~64'h1F);
    check("ac_ready_busy", 64'(rsp.ac_ready), 64'd0);

    // Stray result pulse while the lookup is still pending must be ignored.
    cif.result_valid_i = 1'b1;
    cif.hit_i = 1'b1; cif.dirty_i = 1'b1; cif.unique_i = 1'b1;
    step();
    clear_cache_inputs();
    check("lkp_hold", 64'(cif.lookup_valid_o), 64'd1);
    cif.lookup_ready_i = 1'b1;
    step();
    cif.lookup_ready_i = 1'b0;
    check("lkp_done", 64'(cif.lookup_valid_o), 64'd0);
    step();
    check("cr_early", 64'(rsp.cr_valid), 64'd0);
    check("upd_early", 64'(cif.upd_valid_o), 64'd0);

    cif.result_valid_i = 1'b1;
    cif.hit_i = hit; cif.dirty_i = dirty; cif.unique_i = uniq;
    if (!stall) cif.upd_ready_i = 1'b1;
    step();
    cif.result_valid_i = 1'b0;
    cif.hit_i = 1'b0; cif.dirty_i = 1'b0; cif.unique_i = 1'b0;

    if (exp_upd) begin
      check("upd_valid", 64'(cif.upd_valid_o), 64'd1);
      check("upd_state", 64'(cif.upd_state_o), 64'(exp_ust));
      check("cr_before_upd", 64'(rsp.cr_valid), 64'd0);
      if (stall) begin
        step();
        check("upd_hold", 64'(cif.upd_valid_o), 64'd1);
        check("upd_state_hold", 64'(cif.upd_state_o), 64'(exp_ust));
        cif.upd_ready_i = 1'b1;
      end
      step();
    end else begin
      check("upd_none", 64'(cif.upd_valid_o), 64'd0);
    end
    cif.upd_ready_i = 1'b0;

    check("cr_valid", 64'(rsp.cr_valid), 64'd1);
    check("cr_resp", 64'(rsp.cr.resp), 64'(exp_resp));
    check("lkp_quiet", 64'(cif.lookup_valid_o), 64'd0);
    check("cd_before_cr", 64'(rsp.cd_valid), 64'd0);
    if (stall) begin
      step();
      check("cr_hold", 64'(rsp.cr_valid), 64'd1);
      check("cr_resp_hold", 64'(rsp.cr.resp), 64'(exp_resp));
    end
    req.cr_ready = 1'b1;
    step();
    req.cr_ready = 1'b0;

    if (exp_resp[0]) begin
      for (int b = 0; b < 4; b++) begin
        d = 64'hC0DE_0000_0000_0000 ^ addr ^ 64'(b);
        cif.line_valid_i = 1'b1;
        cif.line_data_i  = d;
        req.cd_ready     = !stall;
        #1;
        check("cd_valid", 64'(rsp.cd_valid), 64'd1);
        check("cd_data", rsp.cd.data, d);
        check("cd_last", 64'(rsp.cd.last), 64'(b == 3));
        if (stall) begin
          check("line_ready_low", 64'(cif.line_ready_o), 64'd0);
          step();
          check("cd_data_stall", rsp.cd.data, d);
          check("cd_last_stall", 64'(rsp.cd.last), 64'(b == 3));
          req.cd_ready = 1'b1;
          #1;
        end
        check("line_ready", 64'(cif.line_ready_o), 64'd1);
        if (b == abort_beat) begin
          rst_n = 1'b0;
          #1;
          check("rst_cd_valid", 64'(rsp.cd_valid), 64'd0);
          check("rst_cr_valid", 64'(rsp.cr_valid), 64'd0);
          check("rst_upd_valid", 64'(cif.upd_valid_o), 64'd0);
          check("rst_lkp_valid", 64'(cif.lookup_valid_o), 64'd0);
          check("rst_line_ready", 64'(cif.line_ready_o), 64'd0);
          clear_cache_inputs();
          req.cd_ready = 1'b0;
          step();
          check("rst_cd_next", 64'(rsp.cd_valid), 64'd0);
          rst_n = 1'b1;
          step();
          check("ac_ready_after_rst", 64'(rsp.ac_ready), 64'd1);
          return;
        end
        step();
      end
      cif.line_valid_i = 1'b0;
      req.cd_ready     = 1'b0;
      #1;
      check("cd_idle", 64'(rsp.cd_valid), 64'd0);
    end else begin
      check("no_cd", 64'(rsp.cd_valid), 64'd0);
    end
    check("ac_ready_after", 64'(rsp.ac_ready), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    req      = '0;
    rst_n    = 1'b0;
    clear_cache_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ac_ready", 64'(rsp.ac_ready), 64'd1);
    check("rst_lkp", 64'(cif.lookup_valid_o), 64'd0);
    check("rst_upd", 64'(cif.upd_valid_o), 64'd0);
    check("rst_cr", 64'(rsp.cr_valid), 64'd0);
    check("rst_cd", 64'(rsp.cd_valid), 64'd0);
    check("rst_cr_resp", 64'(rsp.cr.resp), 64'd0);
    check("rst_line_ready", 64'(cif.line_ready_o), 64'd0);
    rst_n = 1'b1;
    step();

    // ReadShared hit dirty unique
    run_snoop(4'b0001, 64'h0000_1234_5678_9ABF, 1'b1, 1'b1, 1'b1, 5'b11101, 1'b1, 2'd1, 1'b0, 1'b0, -1);
    // MakeInvalid hit
    run_snoop(4'b1101, 64'h0000_0000_0000_1040, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b1, 2'd2, 1'b0, 1'b0, -1);
    // CleanInvalid miss
    run_snoop(4'b1001, 64'h0000_0000_0000_207F, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0, -1);
    // ReadUnique hit clean unique with CD/CR/upd stalls
    run_snoop(4'b0111, 64'hFFFF_0000_0000_3001, 1'b1, 1'b0, 1'b1, 5'b10001, 1'b1, 2'd2, 1'b1, 1'b0, -1);
    // CleanShared hit clean not unique: no data, no update
    run_snoop(4'b1000, 64'h0000_0000_0000_4020, 1'b1, 1'b0, 1'b0, 5'b01000, 1'b0, 2'd0, 1'b0, 1'b0, -1);
    // CleanShared hit dirty unique: data and SHARED_CLEAN
    run_snoop(4'b1000, 64'h0000_0000_0000_5005, 1'b1, 1'b1, 1'b1, 5'b11101, 1'b1, 2'd1, 1'b1, 1'b0, -1);
    // Unsupported code behaves as a miss
    run_snoop(4'b0100, 64'h0000_0000_0000_6000, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0, -1);
    // Back-to-back: ReadOnce with ac_valid held, then CleanInvalid hit dirty unique
    run_snoop(4'b0000, 64'h0000_0000_0000_7010, 1'b1, 1'b0, 1'b0, 5'b01001, 1'b0, 2'd0, 1'b0, 1'b1, -1);
    run_snoop(4'b1001, 64'h0000_0000_0000_8000, 1'b1, 1'b1, 1'b1, 5'b10101, 1'b1, 2'd2, 1'b0, 1'b0, -1);
    // Reset during CD beat 2, then a fresh snoop must frame last on beat 3
    run_snoop(4'b0001, 64'h0000_0000_0000_9000, 1'b1, 1'b0, 1'b1, 5'b11001, 1'b1, 2'd1, 1'b0, 1'b0, 2);
    run_snoop(4'b0001, 64'h0000_0000_0000_A0C0, 1'b1, 1'b0, 1'b0, 5'b01001, 1'b1, 2'd1, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
